loader_sequencer: RTL



---
 rtl/loader_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/loader_sequencer.sv
// loader_sequencer: initiator of the hierarchical loader tree.
// Queues host commands and replays them as setup/select/gap waveforms.
module loader_sequencer #(
    parameter int ADDRESS_SIZE  = 10,
    parameter int DATA_SIZE     = 8,
    parameter int NB_SLAVES     = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int SELECT_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic [ADDRESS_SIZE-1:0] CMD_ADDRESS,
    input  logic [DATA_SIZE-1:0]    CMD_DATA,
    output logic                    SELECT_LEVEL,
    output logic [ADDRESS_SIZE-1:0] ADDRESS,
    output logic [DATA_SIZE-1:0]    DATA,
    output logic                    BUSY,
    output logic [15:0]             CMD_COUNT,
    output logic                    ADDR_ERROR,
    input  logic                    CLEAR_ERROR
);

    localparam int W    = $clog2(NB_SLAVES + 2);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int NW   = PW + 1;
    localparam int EW   = ADDRESS_SIZE + DATA_SIZE;
    localparam int CMAX = (SELECT_CYCLES > GAP_CYCLES) ? SELECT_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam int unsigned F_MAX = NB_SLAVES + 2;
    localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);
    localparam logic [CW-1:0] SEL_LAST = CW'(SELECT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] SELECT = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    logic [EW-1:0]           fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [NW-1:0]           fifo_cnt;
    logic [NW-1:0]           fifo_cnt_nxt;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic [EW-1:0]           head;
    logic [ADDRESS_SIZE-1:0] head_addr;
    logic [DATA_SIZE-1:0]    head_data;
    logic [W-1:0]            head_field;
    logic                    head_legal;
    logic                    load;
    logic                    reject;

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [CW-1:0]           cyc;
    logic [CW-1:0]           cyc_nxt;
    logic                    issued;

    assign full       = (fifo_cnt == FULL_CNT);
    assign CMD_READY  = RESET && !full;
    assign push       = CMD_VALID && CMD_READY;
    assign pop        = (state == IDLE) && (fifo_cnt != '0);

    assign head       = fifo_mem[rd_ptr];
    assign head_addr  = head[EW-1 -: ADDRESS_SIZE];
    assign head_data  = head[DATA_SIZE-1:0];
    assign head_field = head_addr[ADDRESS_SIZE-1 -: W];
    assign head_legal = (32'(head_field) <= F_MAX);
    assign load       = pop && head_legal;
    assign reject     = pop && !head_legal;

    // Storage needs no reset: READY is held low during reset so nothing lands here.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {CMD_ADDRESS, CMD_DATA};
        end
    end

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        case ({push, pop})
            2'b10:   fifo_cnt_nxt = fifo_cnt + 1'b1;
            2'b01:   fifo_cnt_nxt = fifo_cnt - 1'b1;
            default: fifo_cnt_nxt = fifo_cnt;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        issued    = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = SELECT;
                cyc_nxt   = '0;
            end
            SELECT: begin
                if (cyc == SEL_LAST) begin
                    issued    = 1'b1;
                    cyc_nxt   = '0;
                    state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    cyc_nxt = cyc + 1'b1;
                end
            end
            GAP: begin
                if (cyc == GAP_LAST) begin
                    cyc_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cyc_nxt = cyc + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cyc_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state        <= IDLE;
            cyc          <= '0;
            SELECT_LEVEL <= 1'b0;
            ADDRESS      <= '0;
            DATA         <= '0;
            BUSY         <= 1'b0;
            CMD_COUNT    <= '0;
            ADDR_ERROR   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cyc          <= cyc_nxt;
            SELECT_LEVEL <= (state_nxt == SELECT);
            BUSY         <= (fifo_cnt_nxt != '0) || (state_nxt != IDLE);
            if (load) begin
                ADDRESS <= head_addr;
                DATA    <= head_data;
            end
            if (issued && (CMD_COUNT != 16'hFFFF)) begin
                CMD_COUNT <= CMD_COUNT + 16'd1;
            end
            // A rejection in the same cycle as a clear must remain visible.
            if (reject) begin
                ADDR_ERROR <= 1'b1;
            end else if (CLEAR_ERROR) begin
                ADDR_ERROR <= 1'b0;
            end
        end
    end

endmodule
